mux8_rr_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 26 ++
 rtl/mux8_rr_arbiter_rr_pick.sv | 32 +++
 rtl/mux8_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_mux8_rr_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types, defaults and helpers for the mux8 round-robin arbiter.
// Holds the FSM state enum and the one-hot to index conversion.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  localparam int N_DEFAULT     = 8;
  localparam int SEL_W_DEFAULT = 3;

  // OR-reduce the positions of set bits; exact for one-hot input.
  function automatic logic [SEL_W_DEFAULT-1:0] rr_onehot_to_idx(
    input logic [N_DEFAULT-1:0] oh
  );
    logic [SEL_W_DEFAULT-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_DEFAULT; i++) begin
      if (oh[i]) idx = idx | SEL_W_DEFAULT'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or after ptr.
// Purely combinational; wraps from N-1 back to 0.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int SEL_W = SEL_W_DEFAULT
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any_req
);

  logic [N_DEFAULT-1:0] win;
  logic                 found;

  // Scan ptr, ptr+1, ... modulo N and keep only the first hit.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        win[(int'(ptr) + k) % N] = 1'b1;
        found = 1'b1;
      end
    end
    idx     = SEL_W'(rr_onehot_to_idx(win));
    any_req = |req;
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving a shared mux8 select; registered outputs.
// Optional forced release after MAX_HOLD cycles: define ARB_HOLD_LIMIT_EN.
module mux8_rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = N_DEFAULT,
  parameter int SEL_W    = SEL_W_DEFAULT,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic [SEL_W-1:0] last_gnt
);

  if (SEL_W != $clog2(N) || N < 2 || N > 8 || MAX_HOLD < 2) begin : g_cfg_err
    $error("mux8_rr_arbiter: bad parameter set");
  end

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [SEL_W-1:0] win;
  logic             any_req;
  logic             release_now;
  logic [N-1:0]     one_n;

  assign one_n = {{(N-1){1'b0}}, 1'b1};

  rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .idx     (win),
    .any_req (any_req)
  );

`ifdef ARB_HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD) + 1;
  logic [HW-1:0] hold_q, hold_d;

  // Release when the holder drops req or its time slice is used up.
  assign release_now = !req[sel_q] ||
                       (hold_q == HW'(MAX_HOLD - 1));

  // Grant-length counter; restarts on every new grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end

  // Clear when a grant is issued, count while it is held.
  always_comb begin
    hold_d = hold_q;
    if (state_q == GRANT) hold_d = hold_q + 1'b1;
    else                  hold_d = '0;
  end
`else
  // Without a hold limit only the holder itself ends its grant.
  assign release_now = !req[sel_q];
`endif

  // State and output registers; async reset clears all of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      last_q  <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  // Next state: arbitrate in IDLE/GAP, hold in GRANT until release.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE, GAP: begin
        if (any_req) begin
          sel_d   = win;
          gnt_d   = one_n << win;
          busy_d  = 1'b1;
          state_d = GRANT;
        end else begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (release_now) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          last_d  = sel_q;
          ptr_d   = (sel_q == SEL_W'(N - 1)) ? '0 : sel_q + 1'b1;
          state_d = GAP;
        end
      end
      default: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign gnt      = gnt_q;
  assign sel      = sel_q;
  assign busy     = busy_q;
  assign last_gnt = last_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter against a behavioural model.
// Honours ARB_HOLD_LIMIT_EN the same way the design does.
module tb_mux8_rr_arbiter;

  localparam int N  = 8;
  localparam int MH = 4;
`ifdef ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic [2:0] last_gnt;

  int n_cmp;
  int n_bad;

  // Model: who holds the grant (-1 none), rotation start, history.
  int m_cur;
  int m_ptr;
  int m_sel;
  int m_last;
  int m_hold;

  mux8_rr_arbiter #(
    .N        (N),
    .SEL_W    (3),
    .MAX_HOLD (MH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .sel      (sel),
    .busy     (busy),
    .last_gnt (last_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [7:0] m_gnt();
    logic [7:0] v;
    v = '0;
    if (m_cur >= 0) v[m_cur] = 1'b1;
    return v;
  endfunction

  task automatic m_reset();
    m_cur  = -1;
    m_ptr  = 0;
    m_sel  = 0;
    m_last = 0;
    m_hold = 0;
  endtask

  task automatic m_step(input logic [7:0] r);
    int k;
    if (m_cur >= 0) begin
      if (!r[m_cur] || (HOLD_EN && m_hold == MH - 1)) begin
        m_last = m_cur;
        m_ptr  = (m_cur + 1) % N;
        m_cur  = -1;
      end else begin
        m_hold++;
      end
    end else begin
      k = pick(r, m_ptr);
      if (k >= 0) begin
        m_cur  = k;
        m_sel  = k;
        m_hold = 0;
      end
    end
  endtask

  task automatic cyc(input logic [7:0] r);
    req = r;
    @(posedge clk);
    m_step(r);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req   = '0;
    rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (gnt !== 8'h00 || busy !== 1'b0 || sel !== 3'd0 || last_gnt !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_state: gnt=%h busy=%b sel=%0d last=%0d, want 0",
               gnt, busy, sel, last_gnt);
    end
    cyc(8'h04);
    cyc(8'h04);
    n_cmp++;
    if (gnt !== 8'h04 || sel !== 3'd2) begin
      n_bad++;
      $display("FAIL reset_pre_grant: gnt=%h sel=%0d, want 04/2", gnt, sel);
    end
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    n_cmp++;
    if (gnt !== 8'h00 || busy !== 1'b0 || sel !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_async: gnt=%h busy=%b sel=%0d, want 0/0/0",
               gnt, busy, sel);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(8'h00);
      n_cmp++;
      if (gnt !== m_gnt() || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_idle: gnt=%h busy=%b, want %h/0",
                 gnt, busy, m_gnt());
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    cyc(8'h10);
    n_cmp++;
    if (gnt !== 8'h10 || sel !== 3'd4 || busy !== 1'b1 || gnt !== m_gnt()) begin
      n_bad++;
      $display("FAIL single_grant: gnt=%h sel=%0d busy=%b, want 10/4/1",
               gnt, sel, busy);
    end
    cyc(8'h10);
    cyc(8'h00);
    n_cmp++;
    if (gnt !== 8'h00 || busy !== 1'b0 || last_gnt !== 3'd4) begin
      n_bad++;
      $display("FAIL single_release: gnt=%h busy=%b last=%0d, want 00/0/4",
               gnt, busy, last_gnt);
    end
  endtask

  task automatic test_fairness();
    logic [7:0] w;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      w = 8'h01 << (i % N);
      cyc(8'hFF);
      n_cmp++;
      if (gnt !== w || sel !== 3'(i % N) || gnt !== m_gnt()) begin
        n_bad++;
        $display("FAIL rr_grant%0d: gnt=%h sel=%0d, want %h", i, gnt, sel, w);
      end
      cyc(8'hFF);
      n_cmp++;
      if (gnt !== w) begin
        n_bad++;
        $display("FAIL rr_hold%0d: gnt=%h, want %h", i, gnt, w);
      end
      cyc(8'hFF & ~w);
      n_cmp++;
      if (gnt !== 8'h00 || busy !== 1'b0 || last_gnt !== 3'(i % N)) begin
        n_bad++;
        $display("FAIL rr_gap%0d: gnt=%h busy=%b last=%0d, want 00/0/%0d",
                 i, gnt, busy, last_gnt, i % N);
      end
    end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    cyc(8'h40);
    cyc(8'h00);
    cyc(8'h81);
    n_cmp++;
    if (gnt !== 8'h80 || sel !== 3'd7 || gnt !== m_gnt()) begin
      n_bad++;
      $display("FAIL wrap_7: gnt=%h sel=%0d, want 80/7", gnt, sel);
    end
    cyc(8'h01);
    cyc(8'h01);
    n_cmp++;
    if (gnt !== 8'h01 || sel !== 3'd0) begin
      n_bad++;
      $display("FAIL wrap_0: gnt=%h sel=%0d, want 01/0", gnt, sel);
    end
    cyc(8'h00);
    cyc(8'h02);
    cyc(8'h00);
    cyc(8'h22);
    n_cmp++;
    if (gnt !== 8'h20 || sel !== 3'd5 || gnt !== m_gnt()) begin
      n_bad++;
      $display("FAIL skip_5: gnt=%h sel=%0d, want 20/5", gnt, sel);
    end
    cyc(8'h02);
    cyc(8'h22);
    n_cmp++;
    if (gnt !== 8'h02 || sel !== 3'd1 || gnt !== m_gnt()) begin
      n_bad++;
      $display("FAIL skip_1: gnt=%h sel=%0d, want 02/1", gnt, sel);
    end
    cyc(8'h00);
  endtask

  task automatic test_hold();
    logic [7:0] want;
    do_reset();
`ifdef ARB_HOLD_LIMIT_EN
    for (int t = 0; t < 20; t++) begin
      cyc(8'h03);
      if ((t % 5) == 4) want = 8'h00;
      else              want = ((t / 5) % 2 == 0) ? 8'h01 : 8'h02;
      n_cmp++;
      if (gnt !== want || gnt !== m_gnt()) begin
        n_bad++;
        $display("FAIL hold_limit t=%0d: gnt=%h, want %h", t, gnt, want);
      end
    end
`else
    want = 8'h01;
    for (int t = 0; t < 120; t++) begin
      cyc(8'h03);
      n_cmp++;
      if (gnt !== want || gnt !== m_gnt()) begin
        n_bad++;
        $display("FAIL hold_forever t=%0d: gnt=%h, want %h", t, gnt, want);
      end
    end
`endif
    cyc(8'h00);
    cyc(8'h00);
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic [7:0] w;
    do_reset();
    r = 8'($urandom);
    for (int c = 0; c < 10000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      end
      cyc(r);
      w = m_gnt();
      n_cmp++;
      if (gnt !== w || busy !== (m_cur >= 0) || sel !== 3'(m_sel) ||
          last_gnt !== 3'(m_last)) begin
        n_bad++;
        $display("FAIL rand_model c=%0d: gnt=%h busy=%b sel=%0d last=%0d, want %h/%b/%0d/%0d",
                 c, gnt, busy, sel, last_gnt, w, m_cur >= 0, m_sel, m_last);
      end
      n_cmp++;
      if (!$onehot0(gnt) || (busy === 1'b1 && gnt !== (8'h01 << sel))) begin
        n_bad++;
        $display("FAIL rand_onehot c=%0d: gnt=%h sel=%0d busy=%b, want one-hot matching sel",
                 c, gnt, sel, busy);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req   = '0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_single();
    test_fairness();
    test_wrap_skip();
    test_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
